// File: rtl/sha256_stream.sv
// sha256_stream: streaming SHA-256/SHA-224 core with internal padding and one compression round per cycle.
// Define SHA256_STREAM_OHOLD_EN to add an oready port that holds the result until it is accepted.
module sha256_stream #(
  parameter int IBYTES = 1,
  parameter int IS224  = 0,
  localparam int NBW   = (IBYTES > 1) ? $clog2(IBYTES) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                tvalid,
  output logic                tready,
  input  logic                tlast,
  input  logic [NBW-1:0]      tnb,
  input  logic [31:0]         tid,
  input  logic [8*IBYTES-1:0] tdata,
`ifdef SHA256_STREAM_OHOLD_EN
  input  logic                oready,
`endif
  output logic                ovalid,
  output logic [31:0]         oid,
  output logic [60:0]         olen,
  output logic [255:0]        osha
);

  typedef enum logic [2:0] {IDLE, LOAD, PAD80, PAD0, PADLEN, COMP, FIN, OUT} state_t;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };
  localparam logic [31:0] IV224 [8] = '{
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939, 32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction
  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction
  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction
  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  state_t      state, state_nx, ret, ret_nx;
  logic [7:0]  blk [64];
  logic [31:0] h [8];
  logic [31:0] work [8];
  logic [31:0] cur [8];
  logic [31:0] hsum [8];
  logic [31:0] w [16];
  logic [5:0]  pos, base, rnd;
  logic [6:0]  nbytes, fill_pos, pos_inc;
  logic [60:0] len;
  logic [31:0] id, wt, t1, t2;
  logic [63:0] bitlen;
  logic        last_blk, accept;

  assign tready   = (state == IDLE) || (state == LOAD);
  assign ovalid   = (state == OUT);
  assign accept   = tvalid & tready;
  assign nbytes   = tlast ? (7'(tnb) + 7'd1) : 7'(IBYTES);
  assign base     = (state == IDLE) ? 6'd0 : pos;
  assign fill_pos = {1'b0, base} + nbytes;
  assign pos_inc  = {1'b0, pos} + 7'd1;
  assign bitlen   = {len, 3'b000};

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      ret   <= LOAD;
    end else begin
      state <= state_nx;
      ret   <= ret_nx;
    end
  end

  always_comb begin
    state_nx = state;
    ret_nx   = ret;
    case (state)
      IDLE, LOAD: begin
        if (accept) begin
          if (fill_pos == 7'd64) begin
            state_nx = COMP;
            ret_nx   = tlast ? PAD80 : LOAD;
          end else if (tlast) begin
            state_nx = PAD80;
          end else begin
            state_nx = LOAD;
          end
        end
      end
      PAD80, PAD0: begin
        if (pos_inc == 7'd56) begin
          state_nx = PADLEN;
        end else if (pos_inc == 7'd64) begin
          state_nx = COMP;
          ret_nx   = PAD0;
        end else begin
          state_nx = PAD0;
        end
      end
      PADLEN: state_nx = COMP;
      COMP:   if (rnd == 6'd63) state_nx = FIN;
      FIN:    state_nx = last_blk ? OUT : ret;
`ifdef SHA256_STREAM_OHOLD_EN
      OUT:    if (oready) state_nx = IDLE;
`else
      OUT:    state_nx = IDLE;
`endif
      default: state_nx = IDLE;
    endcase
  end

  // Round 0 reads the chaining value directly, so no separate load cycle is needed.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      cur[i]  = (rnd == 6'd0) ? h[i] : work[i];
      hsum[i] = h[i] + work[i];
    end
    if (rnd < 6'd16)
      wt = {blk[{rnd[3:0], 2'd0}], blk[{rnd[3:0], 2'd1}], blk[{rnd[3:0], 2'd2}], blk[{rnd[3:0], 2'd3}]};
    else
      wt = ssig1(w[14]) + w[9] + ssig0(w[1]) + w[0];
    t1 = cur[7] + bsig1(cur[4]) + ((cur[4] & cur[5]) ^ (~cur[4] & cur[6])) + K[rnd] + wt;
    t2 = bsig0(cur[0]) + ((cur[0] & cur[1]) ^ (cur[0] & cur[2]) ^ (cur[1] & cur[2]));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pos      <= '0;
      rnd      <= '0;
      len      <= '0;
      id       <= '0;
      last_blk <= 1'b0;
      oid      <= '0;
      olen     <= '0;
      osha     <= '0;
      for (int i = 0; i < 64; i++) blk[i] <= '0;
      for (int i = 0; i < 16; i++) w[i] <= '0;
      for (int i = 0; i < 8; i++) begin
        h[i]    <= '0;
        work[i] <= '0;
      end
    end else begin
      case (state)
        IDLE, LOAD: begin
          if (accept) begin
            for (int i = 0; i < IBYTES; i++)
              if (7'(i) < nbytes) blk[base + 6'(i)] <= tdata[8*(IBYTES-i)-1 -: 8];
            pos <= fill_pos[5:0];
            if (state == IDLE) begin
              len      <= 61'(nbytes);
              id       <= tid;
              last_blk <= 1'b0;
              for (int i = 0; i < 8; i++) h[i] <= (IS224 != 0) ? IV224[i] : IV256[i];
            end else begin
              len <= len + 61'(nbytes);
            end
          end
        end
        PAD80: begin
          blk[pos] <= 8'h80;
          pos      <= pos_inc[5:0];
        end
        PAD0: begin
          blk[pos] <= 8'h00;
          pos      <= pos_inc[5:0];
        end
        PADLEN: begin
          for (int i = 0; i < 8; i++) blk[6'(56 + i)] <= bitlen[63-8*i -: 8];
          last_blk <= 1'b1;
          pos      <= '0;
        end
        COMP: begin
          work[0] <= t1 + t2;
          work[1] <= cur[0];
          work[2] <= cur[1];
          work[3] <= cur[2];
          work[4] <= cur[3] + t1;
          work[5] <= cur[4];
          work[6] <= cur[5];
          work[7] <= cur[6];
          for (int i = 0; i < 15; i++) w[i] <= w[i+1];
          w[15] <= wt;
          rnd   <= rnd + 6'd1;
        end
        FIN: begin
          for (int i = 0; i < 8; i++) h[i] <= hsum[i];
          if (last_blk) begin
            osha <= {hsum[0], hsum[1], hsum[2], hsum[3], hsum[4], hsum[5], hsum[6],
                     (IS224 != 0) ? 32'd0 : hsum[7]};
            oid  <= id;
            olen <= len;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_stream.sv
// Scoreboard bench for sha256_stream: SHA-256 and SHA-224 instances share one randomized 4-byte stream.
// Expectations come from published digests or a whole-message reference model; a monitor pops and compares.
`timescale 1ns/1ps
module tb_sha256_stream;
  localparam int IB  = 4;
  localparam int NBW = 2;

  typedef byte unsigned bq_t[$];
  typedef struct {
    logic [31:0]  id;
    logic [60:0]  len;
    logic [255:0] d256;
    logic [255:0] d224;
  } exp_t;

  localparam logic [255:0] ABC256 = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] ABC224 = {224'h23097d223405d8228642a477bda255b32aadbce4bda0b3f7e36c9da7, 32'h0};
  localparam logic [255:0] S56256 = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  localparam logic [31:0] KR [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               rstn, tvalid, tlast;
  logic [NBW-1:0]     tnb;
  logic [31:0]        tid;
  logic [8*IB-1:0]    tdata;
  logic               tready_a, tready_b, ovalid_a, ovalid_b, take;
  logic [31:0]        oid_a, oid_b;
  logic [60:0]        olen_a, olen_b;
  logic [255:0]       osha_a, osha_b;
  int                 checks = 0;
  int                 errors = 0;
  exp_t               sbq[$];

`ifdef SHA256_STREAM_OHOLD_EN
  logic oready = 1'b0;
  assign take = ovalid_a & oready;
  initial forever begin
    @(posedge clk); #1;
    oready = ($urandom_range(3) == 0);
  end
`else
  assign take = ovalid_a;
`endif

  sha256_stream #(.IBYTES(IB), .IS224(0)) u_256 (
    .clk(clk), .rstn(rstn), .tvalid(tvalid), .tready(tready_a), .tlast(tlast), .tnb(tnb),
    .tid(tid), .tdata(tdata),
`ifdef SHA256_STREAM_OHOLD_EN
    .oready(oready),
`endif
    .ovalid(ovalid_a), .oid(oid_a), .olen(olen_a), .osha(osha_a));

  sha256_stream #(.IBYTES(IB), .IS224(1)) u_224 (
    .clk(clk), .rstn(rstn), .tvalid(tvalid), .tready(tready_b), .tlast(tlast), .tnb(tnb),
    .tid(tid), .tdata(tdata),
`ifdef SHA256_STREAM_OHOLD_EN
    .oready(oready),
`endif
    .ovalid(ovalid_b), .oid(oid_b), .olen(olen_b), .osha(osha_b));

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Whole-message reference: pad first, expand the full 64-word schedule, then compress each block.
  function automatic logic [255:0] sha_ref(input bq_t msg, input bit is224);
    bq_t p;
    logic [31:0] hh [8];
    logic [31:0] ws [64];
    logic [31:0] a, b, c, d, e, f, g, hv, x1, x2;
    logic [63:0] bl;
    logic [255:0] r;
    p  = msg;
    bl = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
    if (is224) hh = '{32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
                      32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};
    else       hh = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                      32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    for (int bn = 0; bn < p.size() / 64; bn++) begin
      for (int t = 0; t < 16; t++)
        ws[t] = {p[64*bn+4*t], p[64*bn+4*t+1], p[64*bn+4*t+2], p[64*bn+4*t+3]};
      for (int t = 16; t < 64; t++)
        ws[t] = (rr(ws[t-2], 17) ^ rr(ws[t-2], 19) ^ (ws[t-2] >> 10)) + ws[t-7]
              + (rr(ws[t-15], 7) ^ rr(ws[t-15], 18) ^ (ws[t-15] >> 3)) + ws[t-16];
      {a, b, c, d, e, f, g, hv} = {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
      for (int t = 0; t < 64; t++) begin
        x1 = hv + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KR[t] + ws[t];
        x2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
        {a, b, c, d, e, f, g, hv} = {x1 + x2, a, b, c, d + x1, e, f, g};
      end
      hh[0] += a; hh[1] += b; hh[2] += c; hh[3] += d;
      hh[4] += e; hh[5] += f; hh[6] += g; hh[7] += hv;
    end
    r = {hh[0], hh[1], hh[2], hh[3], hh[4], hh[5], hh[6], hh[7]};
    if (is224) r[31:0] = 32'h0;
    return r;
  endfunction

  function automatic bq_t str2q(input string s);
    bq_t q;
    for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
    return q;
  endfunction

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // One beat with random idle gaps; waits (bounded) for the handshake.
  task automatic put_beat(input logic [8*IB-1:0] d, input bit last, input logic [NBW-1:0] nb,
                          input logic [31:0] id);
    bit hs;
    int cyc;
    while ($urandom_range(3) == 0) begin
      tvalid = 1'b0; tdata = $urandom; tlast = $urandom_range(1);
      @(posedge clk); #1;
    end
    tvalid = 1'b1; tdata = d; tlast = last; tnb = nb; tid = id;
    cyc = 0;
    do begin
      @(negedge clk); hs = tready_a;
      @(posedge clk); #1;
      cyc++;
    end while (!hs && cyc < 1000);
    if (!hs) chk("tready_timeout", 256'(hs), 256'd1);
    tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_msg(input bq_t msg, input logic [31:0] id, input logic [255:0] e256,
                          input logic [255:0] e224);
    exp_t e;
    int n, idx, k, cyc;
    bit bad;
    logic [8*IB-1:0] d;
    n = msg.size(); idx = 0;
    e.id = id; e.len = 61'(n); e.d256 = e256; e.d224 = e224;
    sbq.push_back(e);
    while (idx < n) begin
      k = (n - idx >= IB) ? IB : n - idx;
      d = $urandom;
      for (int j = 0; j < k; j++) d[8*(IB-j)-1 -: 8] = msg[idx+j];
      put_beat(d, (idx + k == n), (idx + k == n) ? NBW'(k - 1) : NBW'($urandom),
               (idx == 0) ? id : $urandom);
      idx += k;
    end
    bad = 1'b0; cyc = 0;
    forever begin
      @(negedge clk);
      if (ovalid_a) break;
      if (tready_a) bad = 1'b1;
      if (++cyc > 1000) break;
    end
    chk("tready_low_until_out", {255'd0, bad | (cyc > 1000)}, 256'd0);
  endtask

  // Scoreboard monitor.
  initial begin
    exp_t e;
    logic [255:0] prev_sha;
    bit hold_prev;
    hold_prev = 1'b0; prev_sha = '0;
    forever begin
      @(negedge clk);
`ifdef SHA256_STREAM_OHOLD_EN
      if (hold_prev && rstn) begin
        chk("hold_ovalid", 256'(ovalid_a), 256'd1);
        chk("hold_osha", osha_a, prev_sha);
        chk("hold_tready", 256'(tready_a), 256'd0);
      end
      hold_prev = rstn && ovalid_a && !oready;
      prev_sha  = osha_a;
`endif
      if (rstn && take) begin
        if (sbq.size() == 0) begin
          chk("unexpected_ovalid", 256'(ovalid_a), 256'd0);
        end else begin
          e = sbq.pop_front();
          chk("osha256", osha_a, e.d256);
          chk("osha224", osha_b, e.d224);
          chk("oid", 256'(oid_a), 256'(e.id));
          chk("olen", 256'(olen_a), 256'(e.len));
          chk("ovalid224", 256'(ovalid_b), 256'd1);
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t m;
    int lens [$];
    int cyc;
    rstn = 1'b0; tvalid = 1'b0; tlast = 1'b0; tnb = '0; tid = '0; tdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_ovalid", 256'(ovalid_a), 256'd0);
    chk("rst_osha", osha_a, 256'd0);
    chk("rst_oid", 256'(oid_a), 256'd0);
    chk("rst_olen", 256'(olen_a), 256'd0);
    @(posedge clk); #1;
    rstn = 1'b1;

    m = str2q("abc");
    send_msg(m, 32'h11, ABC256, ABC224);
    m = str2q("abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq");
    send_msg(m, 32'h22, S56256, sha_ref(m, 1'b1));

    lens = '{1, 2, 4, 5, 55, 56, 57, 63, 64, 65, 119, 120, 128};
    for (int i = 0; i < 5; i++) lens.push_back($urandom_range(1, 200));
    foreach (lens[i]) begin
      m.delete();
      for (int j = 0; j < lens[i]; j++) m.push_back(8'($urandom));
      send_msg(m, $urandom, sha_ref(m, 1'b0), sha_ref(m, 1'b1));
    end

    // Abort a message during its first compression, then hash "abc" cleanly.
    for (int b = 0; b < 64 / IB; b++) put_beat($urandom, 1'b0, NBW'($urandom), 32'hdead);
    repeat (10) @(posedge clk);
    #1 rstn = 1'b0;
    @(negedge clk);
    chk("midrst_ovalid", 256'(ovalid_a), 256'd0);
    chk("midrst_osha256", osha_a, 256'd0);
    chk("midrst_osha224", osha_b, 256'd0);
    chk("midrst_oid", 256'(oid_a), 256'd0);
    chk("midrst_olen", 256'(olen_a), 256'd0);
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    m = str2q("abc");
    send_msg(m, 32'h33, ABC256, ABC224);

    cyc = 0;
    while (sbq.size() != 0 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("scoreboard_drained", 256'(sbq.size()), 256'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
